// File: rtl/timer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_sequencer_if
// Description : Control/status bundle for timer_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             periodic;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] cuenta;
    logic             count_en;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, pause, periodic, limit,
        input  cuenta, count_en, busy, done
    );

    modport slave (
        input  start, stop, pause, periodic, limit,
        output cuenta, count_en, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : timer_sequencer
// Description : One-shot / auto-reload up-counter with pause and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_sequencer #(
    parameter int WIDTH = 4
) (
    input  wire              clk,
    input  wire              rst,
    timer_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_cuenta;
    logic [WIDTH-1:0] w_cuenta_nxt;
    logic [WIDTH-1:0] r_limit_q;
    logic [WIDTH-1:0] w_limit_nxt;
    logic             r_per_q;
    logic             w_per_nxt;
    logic             r_done;
    logic             w_done_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cuenta  <= '0;
            r_limit_q <= '0;
            r_per_q   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cuenta  <= w_cuenta_nxt;
            r_limit_q <= w_limit_nxt;
            r_per_q   <= w_per_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cuenta_nxt = r_cuenta;
        w_limit_nxt  = r_limit_q;
        w_per_nxt    = r_per_q;
        w_done_nxt   = 1'b0;
        if (bus.stop) begin
            // Abort wins over everything, including a terminal-count edge.
            w_state_nxt  = IDLE;
            w_cuenta_nxt = '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        w_limit_nxt  = bus.limit;
                        w_per_nxt    = bus.periodic;
                        w_cuenta_nxt = '0;
                        w_state_nxt  = RUN;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        w_state_nxt = PAUSE;
                    end else if (r_cuenta == r_limit_q) begin
                        w_done_nxt = 1'b1;
                        if (r_per_q) begin
                            w_cuenta_nxt = '0;
                        end else begin
                            w_state_nxt = DONE;
                        end
                    end else begin
                        w_cuenta_nxt = r_cuenta + WIDTH'(1);
                    end
                end
                PAUSE: begin
                    if (!bus.pause) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.cuenta   = r_cuenta;
    assign bus.done     = r_done;
    assign bus.busy     = (r_state == RUN) || (r_state == PAUSE);
    assign bus.count_en = (r_state == RUN) && !bus.pause && !bus.stop;
endmodule
`default_nettype wire

// File: tb/tb_timer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_sequencer
// Description : Directed vector table plus corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_sequencer;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    timer_sequencer_if #(.WIDTH(WIDTH)) bus ();

    timer_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       sp;
        logic       pa;
        logic       pe;
        logic [3:0] lim;
        logic       cen;   // count_en before the edge
        logic [3:0] cu;    // outputs after the edge
        logic       dn;
        logic       bu;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, sp, pa, pe, input logic [3:0] lim,
                       input logic cen, input logic [3:0] cu, input logic dn, bu);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.pe = pe; v.lim = lim;
        v.cen = cen; v.cu = cu; v.dn = dn; v.bu = bu;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic st, sp, pa, pe, input logic [3:0] lim);
        @(negedge clk);
        bus.start = st; bus.stop = sp; bus.pause = pa; bus.periodic = pe; bus.limit = lim;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] cu, input logic dn, bu);
        check({tag, " cuenta"}, 32'(bus.cuenta), 32'(cu));
        check({tag, " done"},   32'(bus.done),   32'(dn));
        check({tag, " busy"},   32'(bus.busy),   32'(bu));
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b0;
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.periodic = 0; bus.limit = '0;

        // One-shot, limit 5
        add(1,0,0,0,5, 0, 0,0,1);
        for (int i = 1; i <= 5; i++) add(0,0,0,0,5, 1, 4'(i),0,1);
        add(0,0,0,0,5, 1, 5,1,0);
        add(0,0,0,0,5, 0, 5,0,0);
        add(0,0,1,0,5, 0, 5,0,0);           // pause ignored in DONE
        // Periodic, limit 3; later limit/periodic changes must not matter
        add(1,0,0,1,3, 0, 0,0,1);
        for (int k = 0; k < 2; k++) begin
            add(0,0,0,0,9, 1, 1,0,1);
            add(0,0,0,0,9, 1, 2,0,1);
            add(0,0,0,0,9, 1, 3,0,1);
            add(0,0,0,0,9, 1, 0,1,1);
        end
        add(1,0,0,0,9, 1, 1,0,1);           // start ignored in RUN
        add(0,1,0,0,9, 0, 0,0,0);           // stop
        // One-shot limit 9 with a 5-cycle pause at cuenta=4
        add(1,0,0,0,9, 0, 0,0,1);
        for (int i = 1; i <= 4; i++) add(0,0,0,0,9, 1, 4'(i),0,1);
        add(0,0,1,0,9, 0, 4,0,1);
        add(0,0,1,0,9, 0, 4,0,1);
        add(1,0,1,0,2, 0, 4,0,1);           // start ignored in PAUSE
        add(0,0,1,0,9, 0, 4,0,1);
        add(0,0,1,0,9, 0, 4,0,1);
        add(0,0,0,0,9, 0, 4,0,1);
        for (int i = 5; i <= 9; i++) add(0,0,0,0,9, 1, 4'(i),0,1);
        add(0,0,0,0,9, 1, 9,1,0);
        add(0,0,0,0,9, 0, 9,0,0);
        // Stop at terminal count together with start and pause
        add(1,0,0,0,7, 0, 0,0,1);
        for (int i = 1; i <= 7; i++) add(0,0,0,0,7, 1, 4'(i),0,1);
        add(1,1,1,0,7, 0, 0,0,0);
        add(0,0,0,0,7, 0, 0,0,0);

        // Asynchronous reset state
        #2 rst = 1'b1;
        #1;
        check_out("reset", 0, 0, 0);
        check("reset count_en", 32'(bus.count_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].sp, vecs[i].pa, vecs[i].pe, vecs[i].lim);
            #1;
            check($sformatf("v%0d count_en", i), 32'(bus.count_en), 32'(vecs[i].cen));
            tick();
            check_out($sformatf("v%0d", i), vecs[i].cu, vecs[i].dn, vecs[i].bu);
        end

        // Async reset mid-run; live limit change ignored
        drive(1,0,0,0,9); tick();
        drive(0,0,0,0,3);
        for (int i = 0; i < 4; i++) tick();
        check_out("latched limit", 4, 0, 1);
        tick(); tick();
        check("run cuenta6", 32'(bus.cuenta), 32'd6);
        #2 rst = 1'b1;
        #1;
        check_out("async rst", 0, 0, 0);
        check("async rst count_en", 32'(bus.count_en), 32'd0);
        #2 rst = 1'b0;
        tick();
        check_out("post rst idle", 0, 0, 0);

        // limit=0 one-shot
        drive(1,0,0,0,0); tick();
        check_out("lim0 start", 0, 0, 1);
        drive(0,0,0,0,0); tick();
        check_out("lim0 done", 0, 1, 0);
        tick();
        check_out("lim0 after", 0, 0, 0);

        // limit=0 periodic fires every cycle
        drive(1,0,0,1,0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0,0,0,0,0); tick();
            check_out($sformatf("lim0 per %0d", i), 0, 1, 1);
        end
        drive(0,1,0,0,0); tick();
        check_out("lim0 per stop", 0, 0, 0);

        // limit=15 periodic wraps modulo 2^WIDTH
        drive(1,0,0,1,15); tick();
        drive(0,0,0,0,15);
        for (int i = 0; i < 15; i++) tick();
        check_out("lim15 top", 15, 0, 1);
        tick();
        check_out("lim15 wrap", 0, 1, 1);
        tick();
        check_out("lim15 next", 1, 0, 1);
        drive(0,1,0,0,0); tick();
        check_out("lim15 stop", 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
`default_nettype wire
